// File: rtl/reg_file_param_if.sv
// Bundle of decode/writeback-facing signals for reg_file_param.
// master = decode/writeback side, slave = register file.
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd0_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic              rd0_pend;
  logic              rd1_pend;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd0_addr, rd1_addr, claim_en, claim_addr, clr_req,
    input  rd0_data, rd1_data, rd0_pend, rd1_pend, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd0_addr, rd1_addr, claim_en, claim_addr, clr_req,
    output rd0_data, rd1_data, rd0_pend, rd1_pend, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x DATA_W storage, two combinational read
// ports, one write port, optional write bypass and hard-wired zero entry,
// per-entry pending scoreboard and a one-entry-per-cycle clear engine.
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic clr_busy;
  logic clr_done;
  logic wr_acc;
  logic claim_acc;
  logic [DATA_W-1:0] rd0_val, rd1_val;

  // Writes and claims are dropped while the sweep owns the array.
  assign wr_acc    = bus.wr_en && !clr_busy && !(ZERO_REG && bus.wr_addr == '0);
  assign claim_acc = bus.claim_en && !clr_busy && !(ZERO_REG && bus.claim_addr == '0);

  // Clear FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear FSM next-state: one entry per SWEEP cycle, ptr wraps on its own.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
        end
      end
      S_SWEEP: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear FSM outputs decoded from state.
  always_comb begin
    clr_busy = (state_q == S_SWEEP);
    clr_done = (state_q == S_DONE);
  end

  // Storage next-state: sweep zeroing, or write then claim (claim wins on a tie).
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (clr_busy) begin
      regs_d[ptr_q] = '0;
      pend_d[ptr_q] = 1'b0;
    end
    if (wr_acc) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (claim_acc) pend_d[bus.claim_addr] = 1'b1;
  end

  // Storage and pending registers.
  // NOTE: the array is reset explicitly because reset must read back as all-zero contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Combinational read ports with optional bypass and zero entry.
  always_comb begin
    rd0_val = regs_q[bus.rd0_addr];
    rd1_val = regs_q[bus.rd1_addr];
    if (BYPASS && wr_acc && bus.wr_addr == bus.rd0_addr) rd0_val = bus.wr_data;
    if (BYPASS && wr_acc && bus.wr_addr == bus.rd1_addr) rd1_val = bus.wr_data;
    if (ZERO_REG && bus.rd0_addr == '0) rd0_val = '0;
    if (ZERO_REG && bus.rd1_addr == '0) rd1_val = '0;
  end

  assign bus.rd0_data = rd0_val;
  assign bus.rd1_data = rd1_val;
  // Pending bits come from registered state only; never bypassed.
  assign bus.rd0_pend = pend_q[bus.rd0_addr] && !(ZERO_REG && bus.rd0_addr == '0);
  assign bus.rd1_pend = pend_q[bus.rd1_addr] && !(ZERO_REG && bus.rd1_addr == '0);
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the 8x16 CPU register file: DEPTH x DATA_W storage with two combinational read ports, one write port, optional write-to-read bypass, and an optional hard-wired zero register. Adds a per-register pending scoreboard for in-flight results, plus a sequential clear engine that zeroes the array one entry per cycle. Sits between decode (read/claim) and writeback (write) in the datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- BYPASS, 1, 1 = an accepted same-cycle write is forwarded to matching read ports
- ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes and claims
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd0_addr, rd1_addr  in  ADDR_W  read addresses
- rd0_data, rd1_data  out  DATA_W  combinational read data
- rd0_pend, rd1_pend  out  1  pending bit of the addressed entry
- claim_en  in  1  mark claim_addr pending (result in flight)
- claim_addr  in  ADDR_W  entry to mark
- clr_req  in  1  start sequential clear
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the sweep completes

## Operation
- Reset (rst=1 at an edge): all entries 0, all pending bits 0, FSM to IDLE, sweep pointer 0; clr_busy=0, clr_done=0. rst overrides every other input, including mid-sweep.
- Write accepted iff wr_en=1, clr_busy=0, and not (ZERO_REG=1 and wr_addr=0). Entry updated at the edge; pend[wr_addr] cleared at the same edge.
- Claim accepted iff claim_en=1, clr_busy=0, and not (ZERO_REG=1 and claim_addr=0); sets pend[claim_addr] at the edge.
- Write and claim to the same address in one cycle: data is written and the pending bit ends set (claim wins).
- Reads: rdN_data = entry[rdN_addr]. ZERO_REG=1 and rdN_addr=0 -> 0. BYPASS=1 and an accepted write with wr_addr=rdN_addr -> wr_data. Both ports may address the same entry.
- rdN_pend = pend[rdN_addr], registered state only; not bypassed. Always 0 for entry 0 when ZERO_REG=1.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 -> SWEEP, ptr=0.
  - SWEEP: each edge entry[ptr] and pend[ptr] are zeroed and ptr increments; at ptr=DEPTH-1 -> DONE.
  - DONE: -> IDLE unconditionally.
  - clr_req is ignored in SWEEP and DONE; it is not queued.
- Writes and claims presented while clr_busy=1 are dropped, not stalled. The caller must hold off on clr_busy.
- Reads during SWEEP return current contents; already-swept entries read 0.
- ptr wraps naturally within ADDR_W bits; no state beyond DEPTH entries.

## Timing
- Read path: zero-cycle, combinational from address (and, with bypass, from wr_en/wr_addr/wr_data).
- Write/claim: visible on the read/pend outputs the cycle after the edge; same cycle through bypass.
- clr_req sampled high in IDLE at edge k: clr_busy=1 during cycles k+1 .. k+DEPTH; clr_done=1 in cycle k+DEPTH+1; clr_busy=0 from then.
- A write accepted in the same cycle as clr_req still commits; the sweep later zeroes it.
- Total clear occupancy: DEPTH+1 cycles from request to IDLE. A new clr_req is accepted the cycle after clr_done.
- Reset is effective at the next edge. Outputs follow from zeroed state in the cycle after reset.

## Test plan
- Reset, then write 0xBEEF to entry 5 and 0x1234 to entry 2. Read rd0=5, rd1=2 next cycle -> 0xBEEF and 0x1234. Before the writes, all entries read 0x0000.
- BYPASS=1: write 0xA5A5 to entry 3 while rd0_addr=rd1_addr=3 -> both ports show 0xA5A5 in the same cycle. BYPASS=0 -> both show the old value that cycle and 0xA5A5 the next.
- ZERO_REG=1: write 0xFFFF and claim on entry 0 -> rd0_data=0 and rd0_pend=0 afterwards. Entry 1 behaves normally.
- Scoreboard: claim 4 -> rd0_pend=1 next cycle. Write 4 -> pend 0. Write and claim 4 in the same cycle -> data updated and pend=1.
- Fill all 8 entries with nonzero values, then pulse clr_req -> clr_busy high for exactly 8 cycles, entry i reads 0 from sweep cycle i+1, clr_done a single pulse, then all entries 0 and all pend bits 0. A write issued during busy is lost.
- Assert rst in sweep cycle 3 -> next cycle clr_busy=0, no clr_done pulse, all entries 0. A new clr_req is then accepted normally.
